// File: rtl/mult_arb_pkg.sv
// Shared constants and types for the two-port multiplier arbiter.
package mult_arb_pkg;

    localparam int unsigned SW_DEFAULT = 24;
    localparam int unsigned NPORT      = 2;
    localparam int unsigned P_FPU      = 0;
    localparam int unsigned P_AUX      = 1;

    // Requester identity, used for the round-robin pointer and the result tag.
    typedef enum logic {
        PORT_FPU = 1'b0,
        PORT_AUX = 1'b1
    } port_e;

endpackage

// File: rtl/mult.sv
// Registered SW x SW unsigned multiplier core: product appears one cycle after the operands.
module mult #(
    parameter int unsigned SW = 24
) (
    input  logic            clk,
    input  logic [SW-1:0]   a,
    input  logic [SW-1:0]   b,
    output logic [2*SW-1:0] p
);

    logic [2*SW-1:0] p_d;
    logic [2*SW-1:0] p_q;

    // Full-width unsigned product, zero-extended so nothing is truncated.
    always_comb begin
        p_d = {{SW{1'b0}}, a} * {{SW{1'b0}}, b};
    end

    // Product register; validity is tracked by the caller, so no reset is needed here.
    always_ff @(posedge clk) begin
        p_q <= p_d;
    end

    assign p = p_q;

endmodule

// File: rtl/mult_rr_arb2.sv
// Two-way round-robin arbiter: a lone eligible port wins, a tie goes to the port not granted last.
module mult_rr_arb2
    import mult_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NPORT-1:0] eligible,
    output logic [NPORT-1:0] grant
);

    port_e last_grant_q;
    port_e last_grant_d;

    // Grant selection and pointer update; the pointer only moves on a real grant.
    always_comb begin
        grant        = '0;
        last_grant_d = last_grant_q;
        if (eligible == 2'b11) begin
            grant = (last_grant_q == PORT_FPU) ? 2'b10 : 2'b01;
        end else begin
            grant = eligible;
        end
        if (grant[P_FPU]) begin
            last_grant_d = PORT_FPU;
        end else if (grant[P_AUX]) begin
            last_grant_d = PORT_AUX;
        end
    end

    // Pointer register; reset marks AUX as last so the FPU port wins the first tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant_q <= PORT_AUX;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Shares one registered multiplier between the FPU mantissa port (0) and the AUX/KOA port (1),
// with a per-port result buffer so back-pressure on one port never stalls the other.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned SW = SW_DEFAULT
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid_0,
    output logic            req_ready_0,
    input  logic [SW-1:0]   req_a_0,
    input  logic [SW-1:0]   req_b_0,
    output logic            res_valid_0,
    input  logic            res_ready_0,
    output logic [2*SW-1:0] res_data_0,
    input  logic            req_valid_1,
    output logic            req_ready_1,
    input  logic [SW-1:0]   req_a_1,
    input  logic [SW-1:0]   req_b_1,
    output logic            res_valid_1,
    input  logic            res_ready_1,
    output logic [2*SW-1:0] res_data_1
);

    logic [NPORT-1:0] req_valid;
    logic [NPORT-1:0] res_ready;
    logic [NPORT-1:0] eligible;
    logic [NPORT-1:0] grant;

    logic [NPORT-1:0]           inflight_q, inflight_d;
    logic [NPORT-1:0]           res_valid_q, res_valid_d;
    logic [NPORT-1:0][2*SW-1:0] res_data_q, res_data_d;
    logic                       issued_q, issued_d;
    port_e                      tag_q, tag_d;

    logic [SW-1:0]   mult_a;
    logic [SW-1:0]   mult_b;
    logic [2*SW-1:0] mult_p;

    assign req_valid = {req_valid_1, req_valid_0};
    assign res_ready = {res_ready_1, res_ready_0};

    // A port may issue when it has nothing in flight and its buffer is empty or draining now.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NPORT; i++) begin
            eligible[i] = rst_n & req_valid[i] & ~inflight_q[i] & (~res_valid_q[i] | res_ready[i]);
        end
    end

    mult_rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .eligible (eligible),
        .grant    (grant)
    );

    // Operand mux onto the shared core; idle cycles present zeros.
    always_comb begin
        mult_a = '0;
        mult_b = '0;
        if (grant[P_FPU]) begin
            mult_a = req_a_0;
            mult_b = req_b_0;
        end else if (grant[P_AUX]) begin
            mult_a = req_a_1;
            mult_b = req_b_1;
        end
    end

    mult #(.SW(SW)) u_mult (
        .clk (clk),
        .a   (mult_a),
        .b   (mult_b),
        .p   (mult_p)
    );

    // Issue tracking and result buffers: the product of an issue is steered to its tagged
    // buffer one cycle later; a drain and a fresh issue on the same port may share a cycle.
    always_comb begin
        inflight_d  = inflight_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        issued_d    = |grant;
        tag_d       = tag_q;

        if (grant[P_AUX]) begin
            tag_d = PORT_AUX;
        end else if (grant[P_FPU]) begin
            tag_d = PORT_FPU;
        end

        for (int unsigned i = 0; i < NPORT; i++) begin
            if (res_valid_q[i] && res_ready[i]) begin
                res_valid_d[i] = 1'b0;
            end
        end

        if (issued_q) begin
            inflight_d[tag_q]  = 1'b0;
            res_valid_d[tag_q] = 1'b1;
            res_data_d[tag_q]  = mult_p;
        end

        inflight_d = inflight_d | grant;
    end

    // State registers; reset discards any in-flight product and empties both buffers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_q  <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            issued_q    <= 1'b0;
            tag_q       <= PORT_FPU;
        end else begin
            inflight_q  <= inflight_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            issued_q    <= issued_d;
            tag_q       <= tag_d;
        end
    end

    assign req_ready_0 = grant[P_FPU];
    assign req_ready_1 = grant[P_AUX];
    assign res_valid_0 = res_valid_q[P_FPU];
    assign res_valid_1 = res_valid_q[P_AUX];
    assign res_data_0  = res_data_q[P_FPU];
    assign res_data_1  = res_data_q[P_AUX];

endmodule

// File: tb/tb_mult_arbiter.sv
// Self-checking bench for mult_arbiter: table vectors, directed corner sequences and
// randomized traffic, all checked against a time-based reference model.
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid_0, req_valid_1;
    logic        req_ready_0, req_ready_1;
    logic [23:0] req_a_0, req_b_0, req_a_1, req_b_1;
    logic        res_valid_0, res_valid_1;
    logic        res_ready_0, res_ready_1;
    logic [47:0] res_data_0, res_data_1;

    int total  = 0;
    int passed = 0;

    // Reference model: per port, whether an op is outstanding, its accept cycle and product.
    int          has [2];
    int          acc [2];
    logic [47:0] prod [2];
    int          lastg;
    int          cyc;

    typedef struct {
        int          port;
        logic [23:0] a;
        logic [23:0] b;
        logic [47:0] exp;
    } vec_t;

    vec_t vecs [9];

    mult_arbiter #(.SW(24)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_0 (req_valid_0),
        .req_ready_0 (req_ready_0),
        .req_a_0     (req_a_0),
        .req_b_0     (req_b_0),
        .res_valid_0 (res_valid_0),
        .res_ready_0 (res_ready_0),
        .res_data_0  (res_data_0),
        .req_valid_1 (req_valid_1),
        .req_ready_1 (req_ready_1),
        .req_a_1     (req_a_1),
        .req_b_1     (req_b_1),
        .res_valid_1 (res_valid_1),
        .res_ready_1 (res_ready_1),
        .res_data_1  (res_data_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic get_rr(input int p);
        return (p == 1) ? req_ready_1 : req_ready_0;
    endfunction

    function automatic logic get_rv(input int p);
        return (p == 1) ? res_valid_1 : res_valid_0;
    endfunction

    function automatic logic [47:0] get_rd(input int p);
        return (p == 1) ? res_data_1 : res_data_0;
    endfunction

    task automatic drive(input int p, input logic v, input logic [23:0] a, input logic [23:0] b);
        if (p == 1) begin
            req_valid_1 = v; req_a_1 = a; req_b_1 = b;
        end else begin
            req_valid_0 = v; req_a_0 = a; req_b_0 = b;
        end
    endtask

    // One clock cycle: compare DUT against the model mid-cycle, then advance the model at the edge.
    task automatic tick();
        logic [1:0]  vin, rdy, rr, rv, avail, elig;
        logic [47:0] rd [2];
        logic [47:0] pa [2];
        logic [47:0] x, y;
        int          g;
        #1;
        vin = {req_valid_1, req_valid_0};
        rdy = {res_ready_1, res_ready_0};
        rr  = {req_ready_1, req_ready_0};
        rv  = {res_valid_1, res_valid_0};
        rd[0] = res_data_0;
        rd[1] = res_data_1;
        x = {24'b0, req_a_0}; y = {24'b0, req_b_0}; pa[0] = x * y;
        x = {24'b0, req_a_1}; y = {24'b0, req_b_1}; pa[1] = x * y;
        for (int i = 0; i < 2; i++) begin
            avail[i] = (has[i] != 0) && (cyc >= acc[i] + 2);
            elig[i]  = rst_n && vin[i] && ((has[i] == 0) || (avail[i] && rdy[i]));
        end
        g = -1;
        if (elig[0] && elig[1]) g = (lastg == 0) ? 1 : 0;
        else if (elig[0])       g = 0;
        else if (elig[1])       g = 1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("req_ready_%0d", i), {47'b0, rr[i]}, {47'b0, (g == i)});
            chk($sformatf("res_valid_%0d", i), {47'b0, rv[i]}, {47'b0, avail[i]});
            if (avail[i]) chk($sformatf("res_data_%0d", i), rd[i], prod[i]);
        end
        @(posedge clk);
        if (!rst_n) begin
            has[0] = 0; has[1] = 0;
            lastg  = 1;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (avail[i] && rdy[i]) has[i] = 0;
                if (g == i) begin
                    has[i]  = 1;
                    acc[i]  = cyc;
                    prod[i] = pa[i];
                    lastg   = i;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        drive(0, 1'b0, '0, '0);
        drive(1, 1'b0, '0, '0);
        res_ready_0 = 1'b1;
        res_ready_1 = 1'b1;
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [47:0] d0;
        int          cnt;

        vecs[0] = '{0, 24'd3,      24'd5,      48'd15};
        vecs[1] = '{0, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};
        vecs[2] = '{0, 24'h000000, 24'hFFFFFF, 48'h0};
        vecs[3] = '{0, 24'hFFFFFF, 24'h000001, 48'hFFFFFF};
        vecs[4] = '{0, 24'h001000, 24'h001000, 48'h1000000};
        vecs[5] = '{1, 24'd12,     24'd12,     48'd144};
        vecs[6] = '{1, 24'h800000, 24'h000002, 48'h1000000};
        vecs[7] = '{1, 24'hABCDEF, 24'h000010, 48'hABCDEF0};
        vecs[8] = '{1, 24'hFFFFFF, 24'hFFFFFF, 48'hFFFFFE000001};

        has[0] = 0; has[1] = 0; acc[0] = 0; acc[1] = 0;
        prod[0] = '0; prod[1] = '0;
        lastg = 1; cyc = 0;

        rst_n = 1'b0;
        drive(0, 1'b1, 24'd7, 24'd9);
        drive(1, 1'b1, 24'd4, 24'd4);
        res_ready_0 = 1'b1;
        res_ready_1 = 1'b1;
        @(negedge clk);

        // Reset: requests held high must not be accepted; buffers come up empty and zero.
        tick();
        tick();
        #1;
        chk("reset_res_data_0", res_data_0, 48'h0);
        chk("reset_res_data_1", res_data_1, 48'h0);
        rst_n = 1'b1;
        idle(2);

        // Single-op vectors on an otherwise idle arbiter: accept, exact 2-cycle latency, product.
        for (int v = 0; v < 9; v++) begin
            drive(vecs[v].port, 1'b1, vecs[v].a, vecs[v].b);
            #1;
            chk("tbl_accept", {47'b0, get_rr(vecs[v].port)}, 48'd1);
            tick();
            drive(vecs[v].port, 1'b0, 24'($urandom), 24'($urandom));
            #1;
            chk("tbl_not_early", {47'b0, get_rv(vecs[v].port)}, 48'd0);
            tick();
            #1;
            chk("tbl_valid", {47'b0, get_rv(vecs[v].port)}, 48'd1);
            chk("tbl_data", get_rd(vecs[v].port), vecs[v].exp);
            tick();
            idle(1);
        end

        // Both ports requesting every cycle: exactly one accept per cycle, alternating.
        res_ready_0 = 1'b1;
        res_ready_1 = 1'b1;
        for (int k = 0; k < 20; k++) begin
            drive(0, 1'b1, 24'($urandom), 24'($urandom));
            drive(1, 1'b1, 24'($urandom), 24'($urandom));
            #1;
            chk("one_accept_per_cycle", {46'b0, {1'b0, req_ready_0} + {1'b0, req_ready_1}}, 48'd1);
            tick();
        end
        idle(3);

        // Port 0 result held under back-pressure while port 1 keeps issuing every other cycle.
        res_ready_0 = 1'b0;
        drive(0, 1'b1, 24'h123456, 24'h00ABCD);
        tick();
        drive(1, 1'b1, 24'd100, 24'd3);
        tick();
        tick();
        #1;
        d0  = res_data_0;
        cnt = 0;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("hold_valid_0", {47'b0, res_valid_0}, 48'd1);
            chk("hold_data_0", res_data_0, d0);
            chk("hold_ready_0", {47'b0, req_ready_0}, 48'd0);
            if (req_ready_1) cnt++;
            drive(1, 1'b1, 24'($urandom), 24'($urandom));
            tick();
        end
        chk("aux_rate_under_backpressure", 48'(cnt), 48'd5);

        // Drain and re-issue on port 0 in the same cycle.
        drive(1, 1'b0, '0, '0);
        res_ready_0 = 1'b1;
        drive(0, 1'b1, 24'h000321, 24'h000123);
        #1;
        chk("reissue_res_valid_0", {47'b0, res_valid_0}, 48'd1);
        chk("reissue_ready_0", {47'b0, req_ready_0}, 48'd1);
        tick();
        idle(4);

        // Reset while an op is in flight: nothing emerges, and the first tie goes to port 0.
        drive(0, 1'b1, 24'd77, 24'd88);
        tick();
        drive(0, 1'b0, '0, '0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("post_reset_res_valid_0", {47'b0, res_valid_0}, 48'd0);
            tick();
        end
        drive(0, 1'b1, 24'd5, 24'd6);
        drive(1, 1'b1, 24'd7, 24'd8);
        #1;
        chk("first_tie_port0", {47'b0, req_ready_0}, 48'd1);
        chk("first_tie_not_port1", {47'b0, req_ready_1}, 48'd0);
        tick();
        idle(3);

        // Randomized traffic with random back-pressure and occasional reset.
        for (int k = 0; k < 400; k++) begin
            rst_n       = ($urandom_range(0, 99) != 0);
            res_ready_0 = ($urandom_range(0, 9) < 7);
            res_ready_1 = ($urandom_range(0, 9) < 6);
            drive(0, ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom),
                  ($urandom_range(0, 7) == 0) ? 24'h000000 : 24'($urandom));
            drive(1, ($urandom_range(0, 9) < 7),
                  24'($urandom), ($urandom_range(0, 7) == 0) ? 24'hFFFFFF : 24'($urandom));
            tick();
        end
        rst_n = 1'b1;
        idle(4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
